rob_ctrl: RTL and testbench
===========================

// Module: rob_ctrl
// PURPOSE
//  Reorder-buffer pointer/status controller between renaming, commit and retire.
//  Allocates up to MACHINE_WIDTH in-order ROB slots per cycle to renaming and records per-slot
//  done/exception status from commit-stage writeback.
//  Selects up to MACHINE_WIDTH in-order retirements per cycle, and clears all state on a pipeline flush.
//  Holds no payload (pc, dst, exception code); those live in the ROB RAM indexed by rob_addr.
// PARAMETERS
//  MACHINE_WIDTH  2   slots allocated/retired per cycle
//  ROB_DEPTH      16  entries; power of 2, >= 2*MACHINE_WIDTH
//  WB_PORTS       4   completion ports (= FU_NUM)
// PORTS
//  clk            in   1                  clock, rising edge
//  resetn         in   1                  reset, asynchronous, active-low
//  alloc_req      in   MW                 per-slot allocate request from renaming; contiguous from bit 0
//  alloc_ok       out  1                  all requested slots granted this cycle
//  rob_addr_new   out  MW*AW              slot i index = tail+i (AW = log2 ROB_DEPTH)
//  complete_valid in   WB_PORTS           writeback of an allocated entry
//  complete_addr  in   WB_PORTS*AW        entry index per port
//  complete_exc   in   WB_PORTS           entry raised an exception
//  retire_valid   out  MW                 slot i retires this cycle; contiguous from bit 0
//  retire_addr    out  MW*AW              slot i index = head+i
//  retire_exc     out  1                  first non-retired window entry is done+exception
//  retire_exc_addr out AW                 index of that entry
//  flush          in   1                  exception unit: discard all entries
//  empty, full    out  1 each             count==0 / count==ROB_DEPTH
//  count          out  AW+1               occupied entries
// BEHAVIOUR
//  - head/tail are AW+1-bit pointers (MSB = wrap bit); count = tail-head mod 2^(AW+1).
//  - Reset: head=tail=0, all done/exc=0; alloc_ok=1 when alloc_req=0, retire_valid=0, retire_exc=0,
//    empty=1, full=0, count=0. All outputs are combinational from registered state plus alloc_req.
//  - Alloc: n=popcount(alloc_req). alloc_ok = (ROB_DEPTH-count >= n), using registered count only;
//    same-cycle retires do not free space. All-or-nothing: on !alloc_ok nothing allocates.
//    On grant, tail += n, done/exc of the new entries cleared. Non-contiguous alloc_req is illegal (assert).
//  - Complete: at the edge, done[addr]=1 and exc[addr]|=complete_exc. Ports targeting distinct entries
//    apply in parallel; duplicate addresses OR together. Completion of an unallocated entry is
//    ignored (assertion fires).
//  - Retire window: entries head..head+MW-1 (mod depth), limited to count.
//    retire_valid[i] = i<count & done & !exc & retire_valid[i-1].
//    At the first entry that is done&exc with all earlier window entries retiring: retire_exc=1,
//    retire_exc_addr=its index. That entry never retires; it stays at head until flush.
//    head += popcount(retire_valid).
//  - Latency: a completion is visible to retire the cycle after complete_valid
//    (registered done, no bypass). Alloc→complete→retire minimum is 2 cycles.
//  - Wrap: indices wrap mod ROB_DEPTH; full vs empty is distinguished by the wrap bit.
//    Exactly ROB_DEPTH entries is legal (full=1).
//  - Simultaneous alloc+retire: both applied; tail and head update independently.
//  - flush: highest priority. Next cycle head=tail=0, all done/exc=0. Same-cycle alloc, complete and
//    retire updates are dropped (combinational retire_valid outputs that cycle are still presented;
//    the retire consumer gates them with flush).
//  - Async reset asserted mid-operation clears state immediately, regardless of clk.
// STRUCTURE
//  - rob_pkg: ROB_DEPTH, rob_addr_t (AW bits), rob_ptr_t (AW+1 bits),
//    rob_status_t {done, exc}.
//  - One sub-module: rob_retire_sel, a combinational window picker (head, count, status
//    vector → retire_valid/addr, retire_exc). Everything else lives in rob_ctrl.
// TESTING
//  1 reset, alloc_req=2'b11 → alloc_ok=1, rob_addr_new={1,0}; next cycle count=2, tail=2.
//  2 complete addr1 then addr0 on separate cycles → no retire until addr0 done; the cycle after addr0's
//    complete, retire_valid=2'b11 with addr {1,0}; empty=1 the following cycle.
//  3 fill to 15, alloc_req=2'b11 → alloc_ok=0, count stays 15; alloc_req=2'b01 → ok, full=1.
//  4 entries 0,1 done, exc on entry 0 → retire_valid=0, retire_exc=1, retire_exc_addr=0;
//    flush → next cycle count=0, head=tail=0.
//  5 wrap: head=tail=14, alloc 2, complete both → rob_addr_new={15,14}, retire {15,14};
//    pointers land at wrap bit=1, index 0.
//  6 flush in the same cycle as alloc 2 + complete → count=0 next cycle, done bits all clear.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared ROB sizing, index/pointer types and per-entry status.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_AW    = $clog2(ROB_DEPTH);

  // Entry index and wrap-extended pointer (MSB distinguishes full from empty).
  typedef logic [ROB_AW-1:0] rob_addr_t;
  typedef logic [ROB_AW:0]   rob_ptr_t;

  typedef struct packed {
    logic done;
    logic exc;
  } rob_status_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Combinational retire window picker: walks head..head+MW-1 and stops at the
// first entry that is not done or that raised an exception.
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int unsigned MACHINE_WIDTH = 2
) (
  input  logic [ROB_AW-1:0]               head_idx_i,
  input  logic [ROB_AW:0]                 count_i,
  input  rob_status_t [ROB_DEPTH-1:0]     status_i,
  output logic [MACHINE_WIDTH-1:0]        retire_valid_o,
  output logic [MACHINE_WIDTH*ROB_AW-1:0] retire_addr_o,
  output logic                            retire_exc_o,
  output logic [ROB_AW-1:0]               retire_exc_addr_o
);

  logic      chain;
  rob_addr_t idx;

  // In-order window scan; chain drops at the first non-retiring entry.
  always_comb begin
    retire_valid_o    = '0;
    retire_addr_o     = '0;
    retire_exc_o      = 1'b0;
    retire_exc_addr_o = '0;
    chain             = 1'b1;
    idx               = '0;
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      idx = head_idx_i + rob_addr_t'(i);
      retire_addr_o[i*ROB_AW +: ROB_AW] = idx;
      if (chain && (rob_ptr_t'(i) < count_i)) begin
        if (status_i[idx].done && !status_i[idx].exc) begin
          retire_valid_o[i] = 1'b1;
        end else begin
          // An excepting entry is reported but never retires; it waits for flush.
          if (status_i[idx].done) begin
            retire_exc_o      = 1'b1;
            retire_exc_addr_o = idx;
          end
          chain = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer pointer/status controller: in-order allocation, completion
// tracking, in-order retirement and flush. Payload lives in an external RAM.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned MACHINE_WIDTH = 2,
  parameter int unsigned WB_PORTS      = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [MACHINE_WIDTH-1:0]        alloc_req,
  output logic                            alloc_ok,
  output logic [MACHINE_WIDTH*ROB_AW-1:0] rob_addr_new,
  input  logic [WB_PORTS-1:0]             complete_valid,
  input  logic [WB_PORTS*ROB_AW-1:0]      complete_addr,
  input  logic [WB_PORTS-1:0]             complete_exc,
  output logic [MACHINE_WIDTH-1:0]        retire_valid,
  output logic [MACHINE_WIDTH*ROB_AW-1:0] retire_addr,
  output logic                            retire_exc,
  output logic [ROB_AW-1:0]               retire_exc_addr,
  input  logic                            flush,
  output logic                            empty,
  output logic                            full,
  output logic [ROB_AW:0]                 count
);

  rob_ptr_t                    head_q, head_d;
  rob_ptr_t                    tail_q, tail_d;
  rob_status_t [ROB_DEPTH-1:0] status_q, status_d;

  rob_ptr_t                    alloc_n;
  rob_ptr_t                    retire_n;
  logic [WB_PORTS-1:0]         comp_ok;
  logic [WB_PORTS-1:0]         comp_stray;
  rob_addr_t                   comp_off;

  // Occupancy and flags from registered pointers only.
  always_comb begin
    count = tail_q - head_q;
    empty = (count == '0);
    full  = (count == rob_ptr_t'(ROB_DEPTH));
  end

  // Allocation grant: all-or-nothing against space before this cycle's retires.
  always_comb begin
    alloc_n      = '0;
    rob_addr_new = '0;
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      alloc_n = alloc_n + rob_ptr_t'(alloc_req[i]);
      rob_addr_new[i*ROB_AW +: ROB_AW] = tail_q[ROB_AW-1:0] + rob_addr_t'(i);
    end
    alloc_ok = ((rob_ptr_t'(ROB_DEPTH) - count) >= alloc_n);
  end

  // A completion is accepted only if its entry sits inside [head, tail).
  always_comb begin
    comp_ok    = '0;
    comp_stray = '0;
    comp_off   = '0;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      comp_off      = complete_addr[p*ROB_AW +: ROB_AW] - head_q[ROB_AW-1:0];
      comp_ok[p]    = ({1'b0, comp_off} < count);
      comp_stray[p] = complete_valid[p] & ~comp_ok[p];
    end
  end

  rob_retire_sel #(
    .MACHINE_WIDTH(MACHINE_WIDTH)
  ) u_retire_sel (
    .head_idx_i       (head_q[ROB_AW-1:0]),
    .count_i          (count),
    .status_i         (status_q),
    .retire_valid_o   (retire_valid),
    .retire_addr_o    (retire_addr),
    .retire_exc_o     (retire_exc),
    .retire_exc_addr_o(retire_exc_addr)
  );

  // Number of entries leaving at head this cycle.
  always_comb begin
    retire_n = '0;
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      retire_n = retire_n + rob_ptr_t'(retire_valid[i]);
    end
  end

  // Next state: completions, allocation clears, pointer moves; flush overrides all.
  always_comb begin
    head_d   = head_q + retire_n;
    tail_d   = tail_q;
    status_d = status_q;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (complete_valid[p] && comp_ok[p]) begin
        status_d[complete_addr[p*ROB_AW +: ROB_AW]].done = 1'b1;
        status_d[complete_addr[p*ROB_AW +: ROB_AW]].exc  =
          status_d[complete_addr[p*ROB_AW +: ROB_AW]].exc | complete_exc[p];
      end
    end
    if (alloc_ok) begin
      tail_d = tail_q + alloc_n;
      for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
        if (alloc_req[i]) begin
          status_d[tail_q[ROB_AW-1:0] + rob_addr_t'(i)] = '0;
        end
      end
    end
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      status_d = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      status_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      status_q <= status_d;
    end
  end

  // Requests must be packed from slot 0 upward.
  a_alloc_contig : assert property (@(posedge clk) disable iff (!resetn)
    ((alloc_req & (alloc_req + MACHINE_WIDTH'(1))) == '0));

  // Writeback must target a live entry.
  a_comp_live : assert property (@(posedge clk) disable iff (!resetn)
    (comp_stray == '0));

endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed scenarios plus a randomized run
// against an integer-pointer reference model.
module tb_rob_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  alloc_req;
  logic        alloc_ok;
  logic [7:0]  rob_addr_new;
  logic [3:0]  complete_valid;
  logic [15:0] complete_addr;
  logic [3:0]  complete_exc;
  logic [1:0]  retire_valid;
  logic [7:0]  retire_addr;
  logic        retire_exc;
  logic [3:0]  retire_exc_addr;
  logic        flush;
  logic        empty;
  logic        full;
  logic [4:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_ctrl #(
    .MACHINE_WIDTH(2),
    .WB_PORTS     (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .alloc_req      (alloc_req),
    .alloc_ok       (alloc_ok),
    .rob_addr_new   (rob_addr_new),
    .complete_valid (complete_valid),
    .complete_addr  (complete_addr),
    .complete_exc   (complete_exc),
    .retire_valid   (retire_valid),
    .retire_addr    (retire_addr),
    .retire_exc     (retire_exc),
    .retire_exc_addr(retire_exc_addr),
    .flush          (flush),
    .empty          (empty),
    .full           (full),
    .count          (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req      = 2'b00;
    complete_valid = 4'b0000;
    complete_addr  = 16'h0000;
    complete_exc   = 4'b0000;
    flush          = 1'b0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    idle();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic complete2(input int a0, input int a1, input bit e0, input bit e1);
    complete_valid = 4'b0011;
    complete_addr  = {8'h00, 4'(a1), 4'(a0)};
    complete_exc   = {2'b00, e1, e0};
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (alloc_ok !== 1'b1) begin bad++; $display("FAIL reset_alloc_ok got=%b want=1", alloc_ok); end
    total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL reset_retire_valid got=%b want=00", retire_valid); end
    total++; if (retire_exc !== 1'b0) begin bad++; $display("FAIL reset_retire_exc got=%b want=0", retire_exc); end
  endtask

  task automatic test_alloc_basic();
    alloc_req = 2'b11;
    #1;
    total++; if (alloc_ok !== 1'b1) begin bad++; $display("FAIL alloc_ok got=%b want=1", alloc_ok); end
    total++; if (rob_addr_new !== 8'h10) begin bad++; $display("FAIL alloc_addr got=%h want=10", rob_addr_new); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd2) begin bad++; $display("FAIL alloc_count got=%0d want=2", count); end
    total++; if (rob_addr_new !== 8'h32) begin bad++; $display("FAIL alloc_tail got=%h want=32", rob_addr_new); end
  endtask

  task automatic test_complete_retire();
    complete_valid = 4'b0001;
    complete_addr  = 16'h0001;
    #1;
    total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL cr_early got=%b want=00", retire_valid); end
    tick();
    complete_addr = 16'h0000;
    #1;
    total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL cr_no_bypass got=%b want=00", retire_valid); end
    tick();
    idle();
    #1;
    total++; if (retire_valid !== 2'b11) begin bad++; $display("FAIL cr_retire got=%b want=11", retire_valid); end
    total++; if (retire_addr !== 8'h10) begin bad++; $display("FAIL cr_retire_addr got=%h want=10", retire_addr); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL cr_empty got=%b want=1", empty); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      alloc_req = 2'b11;
      tick();
    end
    alloc_req = 2'b01;
    tick();
    alloc_req = 2'b11;
    #1;
    total++; if (alloc_ok !== 1'b0) begin bad++; $display("FAIL full_deny got=%b want=0", alloc_ok); end
    tick();
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_hold got=%0d want=15", count); end
    alloc_req = 2'b01;
    #1;
    total++; if (alloc_ok !== 1'b1) begin bad++; $display("FAIL full_last_ok got=%b want=1", alloc_ok); end
    tick();
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", count); end
    total++; if (alloc_ok !== 1'b0) begin bad++; $display("FAIL full_deny1 got=%b want=0", alloc_ok); end
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL full_flush got=%0d want=0", count); end
  endtask

  task automatic test_exception_flush();
    apply_reset();
    alloc_req = 2'b11;
    tick();
    idle();
    complete2(0, 1, 1'b1, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL exc_retire_valid got=%b want=00", retire_valid); end
      total++; if (retire_exc !== 1'b1) begin bad++; $display("FAIL exc_flag got=%b want=1", retire_exc); end
      total++; if (retire_exc_addr !== 4'd0) begin bad++; $display("FAIL exc_addr got=%0d want=0", retire_exc_addr); end
      total++; if (count !== 5'd2) begin bad++; $display("FAIL exc_count got=%0d want=2", count); end
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL exc_flush_count got=%0d want=0", count); end
    total++; if (rob_addr_new !== 8'h10) begin bad++; $display("FAIL exc_flush_tail got=%h want=10", rob_addr_new); end
    total++; if (retire_addr !== 8'h10) begin bad++; $display("FAIL exc_flush_head got=%h want=10", retire_addr); end
    total++; if (retire_exc !== 1'b0) begin bad++; $display("FAIL exc_flush_flag got=%b want=0", retire_exc); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      idle();
      alloc_req = 2'b11;
      if (k > 0) complete2(2 * k - 2, 2 * k - 1, 1'b0, 1'b0);
      tick();
    end
    idle();
    complete2(12, 13, 1'b0, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 12; k++) begin
      if (count == 5'd0) break;
      tick();
    end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL wrap_drain got=%0d want=0", count); end
    total++; if (retire_addr !== 8'hFE) begin bad++; $display("FAIL wrap_head got=%h want=fe", retire_addr); end
    alloc_req = 2'b11;
    #1;
    total++; if (rob_addr_new !== 8'hFE) begin bad++; $display("FAIL wrap_alloc_addr got=%h want=fe", rob_addr_new); end
    tick();
    idle();
    complete2(14, 15, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    total++; if (retire_valid !== 2'b11) begin bad++; $display("FAIL wrap_retire got=%b want=11", retire_valid); end
    total++; if (retire_addr !== 8'hFE) begin bad++; $display("FAIL wrap_retire_addr got=%h want=fe", retire_addr); end
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
    total++; if (rob_addr_new !== 8'h10) begin bad++; $display("FAIL wrap_tail0 got=%h want=10", rob_addr_new); end
    total++; if (retire_addr !== 8'h10) begin bad++; $display("FAIL wrap_head0 got=%h want=10", retire_addr); end
    for (int k = 0; k < 8; k++) begin
      alloc_req = 2'b11;
      tick();
    end
    idle();
    #1;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b want=1", full); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL wrap_not_empty got=%b want=0", empty); end
  endtask

  task automatic test_flush_same_cycle();
    apply_reset();
    alloc_req = 2'b11;
    tick();
    complete2(0, 1, 1'b0, 1'b0);
    alloc_req = 2'b11;
    flush     = 1'b1;
    #1;
    total++; if (alloc_ok !== 1'b1) begin bad++; $display("FAIL fsc_alloc_ok got=%b want=1", alloc_ok); end
    total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL fsc_retire got=%b want=00", retire_valid); end
    tick();
    idle();
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL fsc_count got=%0d want=0", count); end
    total++; if (rob_addr_new !== 8'h10) begin bad++; $display("FAIL fsc_tail got=%h want=10", rob_addr_new); end
    alloc_req = 2'b11;
    tick();
    idle();
    #1;
    total++; if (retire_valid !== 2'b00) begin bad++; $display("FAIL fsc_stale_done got=%b want=00", retire_valid); end
    total++; if (count !== 5'd2) begin bad++; $display("FAIL fsc_realloc got=%0d want=2", count); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    alloc_req = 2'b11;
    tick();
    idle();
    total++; if (count !== 5'd2) begin bad++; $display("FAIL ar_pre got=%0d want=2", count); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL ar_clear got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_empty got=%b want=1", empty); end
    tick();
    resetn = 1'b1;
  endtask

  // Reference model: unbounded integer pointers, index = ptr mod 16.
  task automatic test_random();
    bit       m_done[16];
    bit       m_exc[16];
    int       m_head, m_tail, cnt, n, nret, a;
    bit       e_ok, e_exc, stuck;
    int       e_exc_addr;
    logic [1:0] e_valid;
    logic [7:0] e_new, e_raddr;
    apply_reset();
    m_head = 0;
    m_tail = 0;
    for (int j = 0; j < 16; j++) begin m_done[j] = 1'b0; m_exc[j] = 1'b0; end
    for (int c = 0; c < 600; c++) begin
      cnt = m_tail - m_head;
      idle();
      case ($urandom_range(0, 2))
        0: alloc_req = 2'b00;
        1: alloc_req = 2'b01;
        default: alloc_req = 2'b11;
      endcase
      n = (alloc_req == 2'b11) ? 2 : (alloc_req == 2'b01) ? 1 : 0;
      for (int p = 0; p < 4; p++) begin
        if (cnt > 0 && $urandom_range(0, 1) == 1) begin
          a = (m_head + int'($urandom_range(0, cnt - 1))) % 16;
          complete_valid[p]        = 1'b1;
          complete_addr[p*4 +: 4]  = 4'(a);
          complete_exc[p]          = ($urandom_range(0, 7) == 0);
        end
      end
      e_ok       = ((16 - cnt) >= n);
      e_valid    = 2'b00;
      e_exc      = 1'b0;
      e_exc_addr = 0;
      e_new      = 8'h00;
      e_raddr    = 8'h00;
      nret       = 0;
      for (int i = 0; i < 2; i++) begin
        e_new[i*4 +: 4]   = 4'((m_tail + i) % 16);
        e_raddr[i*4 +: 4] = 4'((m_head + i) % 16);
      end
      for (int i = 0; i < 2; i++) begin
        if (i >= cnt) break;
        a = (m_head + i) % 16;
        if (m_done[a] && !m_exc[a]) begin
          e_valid[i] = 1'b1;
          nret++;
        end else begin
          if (m_done[a]) begin e_exc = 1'b1; e_exc_addr = a; end
          break;
        end
      end
      stuck = e_exc;
      flush = ($urandom_range(0, 31) == 0) || (stuck && $urandom_range(0, 3) == 0);
      #1;
      total++; if (alloc_ok !== e_ok) begin bad++; $display("FAIL rnd_alloc_ok c=%0d got=%b want=%b", c, alloc_ok, e_ok); end
      total++; if (rob_addr_new !== e_new) begin bad++; $display("FAIL rnd_addr_new c=%0d got=%h want=%h", c, rob_addr_new, e_new); end
      total++; if (retire_valid !== e_valid) begin bad++; $display("FAIL rnd_retire_valid c=%0d got=%b want=%b", c, retire_valid, e_valid); end
      total++; if (retire_addr !== e_raddr) begin bad++; $display("FAIL rnd_retire_addr c=%0d got=%h want=%h", c, retire_addr, e_raddr); end
      total++; if (retire_exc !== e_exc) begin bad++; $display("FAIL rnd_retire_exc c=%0d got=%b want=%b", c, retire_exc, e_exc); end
      if (e_exc) begin
        total++; if (retire_exc_addr !== 4'(e_exc_addr)) begin bad++; $display("FAIL rnd_exc_addr c=%0d got=%0d want=%0d", c, retire_exc_addr, e_exc_addr); end
      end
      total++; if (count !== 5'(cnt)) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, cnt); end
      total++; if (empty !== (cnt == 0)) begin bad++; $display("FAIL rnd_empty c=%0d got=%b want=%b", c, empty, (cnt == 0)); end
      total++; if (full !== (cnt == 16)) begin bad++; $display("FAIL rnd_full c=%0d got=%b want=%b", c, full, (cnt == 16)); end
      tick();
      if (flush) begin
        m_head = 0;
        m_tail = 0;
        for (int j = 0; j < 16; j++) begin m_done[j] = 1'b0; m_exc[j] = 1'b0; end
      end else begin
        for (int p = 0; p < 4; p++) begin
          if (complete_valid[p]) begin
            a = int'(complete_addr[p*4 +: 4]);
            m_done[a] = 1'b1;
            m_exc[a]  = m_exc[a] | complete_exc[p];
          end
        end
        if (e_ok) begin
          for (int i = 0; i < n; i++) begin
            m_done[(m_tail + i) % 16] = 1'b0;
            m_exc[(m_tail + i) % 16]  = 1'b0;
          end
          m_tail = m_tail + n;
        end
        m_head = m_head + nret;
      end
    end
    idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alloc_basic();
    test_complete_retire();
    test_full();
    test_exception_flush();
    test_wrap();
    test_flush_same_cycle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
